// File: rtl/hamming_encoder_serial.sv
// rtl/hamming_encoder_serial.sv - bit-serial Hamming(21,16) encoder
//
// Purpose: this block takes a 16-bit word and walks codeword positions 1..21,
// one position per clock. It collects 5 even-parity bits and then presents
// the 21-bit codeword. Position k of the codeword is on out_code[k-1].
// Parity bit p[j] sits at position 2^j. Data bits d[0]..d[15] fill the
// remaining positions in ascending order.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    data word to encode
//   in_valid   in_data valid
//   in_ready   encoder idle and able to accept a word
//   out_code   encoded codeword
//   out_par    parity bits p[4:0]
//   out_valid  out_code/out_par valid, held until out_ready
//   out_ready  consumer accepts the codeword
//   busy       high while positions are being walked
//   inj_pos    (HAMMING_ENC_ERR_INJ_EN only) codeword position to invert, 1..21
//
// Optional feature macro: HAMMING_ENC_ERR_INJ_EN
module hamming_encoder_serial #(
  parameter int DATA_W = 16,
  parameter int CODE_W = 21,
  parameter int PAR_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef HAMMING_ENC_ERR_INJ_EN
  input  logic [PAR_W-1:0]  inj_pos,
`endif
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CODE_W-1:0] out_code,
  output logic [PAR_W-1:0]  out_par,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [PAR_W-1:0] LAST_POS = PAR_W'(CODE_W);

  state_t            state_q, state_d;
  logic [PAR_W-1:0]  pos_q;
  logic [PAR_W-1:0]  acc_q;
  logic [DATA_W-1:0] sr_q;
  logic [CODE_W-1:0] code_q;
  logic [CODE_W-1:0] code_full;
  logic [CODE_W-1:0] inj_mask;
  logic [CODE_W-1:0] out_code_q;
  logic [PAR_W-1:0]  out_par_q;
  logic              out_valid_q;
  logic              pos_is_pow2;

  // Parity positions are the powers of two. pos is never 0 while in CALC.
  assign pos_is_pow2 = ((pos_q & (pos_q - PAR_W'(1))) == '0);

  // Place the accumulated parity bits into the data-only working codeword.
  always_comb begin
    code_full     = code_q;
    code_full[0]  = acc_q[0];
    code_full[1]  = acc_q[1];
    code_full[3]  = acc_q[2];
    code_full[7]  = acc_q[3];
    code_full[15] = acc_q[4];
  end

`ifdef HAMMING_ENC_ERR_INJ_EN
  logic [PAR_W-1:0] inj_q;

  always_comb begin
    inj_mask = '0;
    if ((inj_q != '0) && (inj_q <= LAST_POS))
      inj_mask = CODE_W'(1) << (inj_q - PAR_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      inj_q <= '0;
    else if ((state_q == IDLE) && in_valid)
      inj_q <= inj_pos;
  end
`else
  assign inj_mask = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = CALC;
      CALC: if (pos_q == LAST_POS) state_d = DONE;
      DONE: if (out_valid_q && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q       <= '0;
      acc_q       <= '0;
      sr_q        <= '0;
      code_q      <= '0;
      out_code_q  <= '0;
      out_par_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sr_q   <= in_data;
            acc_q  <= '0;
            code_q <= '0;
            pos_q  <= PAR_W'(1);
          end
        end
        CALC: begin
          if (pos_q != LAST_POS)
            pos_q <= pos_q + PAR_W'(1);
          if (!pos_is_pow2) begin
            code_q <= code_q | (CODE_W'(sr_q[0]) << (pos_q - PAR_W'(1)));
            sr_q   <= sr_q >> 1;
            if (sr_q[0])
              acc_q <= acc_q ^ pos_q;
          end
        end
        DONE: begin
          // The first DONE cycle registers the finished codeword. The output
          // registers then hold it stable until the consumer takes it.
          if (!out_valid_q) begin
            out_code_q  <= code_full ^ inj_mask;
            out_par_q   <= acc_q;
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == CALC);
  assign out_code  = out_code_q;
  assign out_par   = out_par_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_hamming_encoder_serial.sv
// tb/tb_hamming_encoder_serial.sv - directed self-checking bench for hamming_encoder_serial
module tb_hamming_encoder_serial;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [20:0] out_code;
  logic [4:0]  out_par;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
`ifdef HAMMING_ENC_ERR_INJ_EN
  logic [4:0]  inj_pos;
`endif

  int total = 0;
  int bad   = 0;

  hamming_encoder_serial dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef HAMMING_ENC_ERR_INJ_EN
    .inj_pos   (inj_pos),
`endif
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_code  (out_code),
    .out_par   (out_par),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a word for one accept edge, then count cycles until out_valid.
  task automatic send_and_wait(input logic [15:0] d, input string tag, output int lat);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'd22);
  endtask

  task automatic take_output(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  int lat;
  logic [20:0] held;

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
`ifdef HAMMING_ENC_ERR_INJ_EN
    inj_pos   = 5'd0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_code", 32'(out_code), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero word
    send_and_wait(16'h0000, "w0000", lat);
    check("w0000_code", 32'(out_code), 32'h000000);
    check("w0000_par", 32'(out_par), 32'h00);
    take_output("w0000");

    // All ones
    send_and_wait(16'hFFFF, "wFFFF", lat);
    check("wFFFF_code", 32'(out_code), 32'h1FFFFE);
    check("wFFFF_par", 32'(out_par), 32'h1E);
    take_output("wFFFF");

    // Lowest data bit lands at position 3
    send_and_wait(16'h0001, "w0001", lat);
    check("w0001_code", 32'(out_code), 32'h000007);
    check("w0001_par", 32'(out_par), 32'h03);
    take_output("w0001");

    // Highest data bit lands at position 21
    send_and_wait(16'h8000, "w8000", lat);
    check("w8000_code", 32'(out_code), 32'h108009);
    check("w8000_par", 32'(out_par), 32'h15);
    take_output("w8000");

    // Backpressure: hold the output for 10 cycles while a second word waits
    send_and_wait(16'h0001, "bp1", lat);
    held     = out_code;
    in_data  = 16'h8000;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_code_stable", 32'(out_code), 32'h000007);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_valid_held", 32'(out_valid), 32'd1);
    end
    check("bp_held_code", 32'(held), 32'h000007);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_back_idle", 32'(in_ready), 32'd1);
    check("bp_not_taken", 32'(busy), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp2_busy", 32'(busy), 32'd1);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    check("bp2_latency", 32'(lat), 32'd22);
    check("bp2_code", 32'(out_code), 32'h108009);
    take_output("bp2");

    // Reset in the middle of CALC, at about pos=10
    in_data  = 16'hFFFF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_out_code", 32'(out_code), 32'h0);
    check("mrst_out_par", 32'(out_par), 32'h0);
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    check("mrst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef HAMMING_ENC_ERR_INJ_EN
    inj_pos = 5'd3;
    send_and_wait(16'h0001, "post_rst", lat);
    inj_pos = 5'd0;
    check("post_rst_code_inj", 32'(out_code), 32'h000003);
    check("post_rst_par", 32'(out_par), 32'h03);
`else
    send_and_wait(16'h0001, "post_rst", lat);
    check("post_rst_code", 32'(out_code), 32'h000007);
    check("post_rst_par", 32'(out_par), 32'h03);
`endif
    take_output("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
